// File: rtl/snake_pkg.sv
// Shared definitions for the snake engine and the game-state FSM that drives it.
package snake_pkg;

  typedef enum logic [1:0] {
    RUNNING = 2'b00,
    DIE     = 2'b01,
    INITIAL = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  function automatic dir_t opposite_dir(input dir_t d);
    case (d)
      UP:      opposite_dir = DOWN;
      DOWN:    opposite_dir = UP;
      LEFT:    opposite_dir = RIGHT;
      default: opposite_dir = LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Bundle of control, query and status signals between the game logic/renderer and the snake engine.
interface snake_engine_if #(
  parameter int COORD_W = 6,
  parameter int LEN_W   = 5
);
  logic               up, down, left, right;
  logic [1:0]         game_state;
  logic [COORD_W-1:0] apple_x, apple_y;
  logic [COORD_W-1:0] query_x, query_y;
  logic               hit_boundary, hit_self, eat;
  logic [COORD_W-1:0] head_x, head_y;
  logic [LEN_W-1:0]   length;
  logic               is_body, is_head;

  modport master (
    output up, down, left, right, game_state, apple_x, apple_y, query_x, query_y,
    input  hit_boundary, hit_self, eat, head_x, head_y, length, is_body, is_head
  );

  modport slave (
    input  up, down, left, right, game_state, apple_x, apple_y, query_x, query_y,
    output hit_boundary, hit_self, eat, head_x, head_y, length, is_body, is_head
  );
endinterface

// File: rtl/move_ticker.sv
// Move-rate divider: emits a one-cycle step on the cycle the counter wraps.
module move_ticker #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic step
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count while running, hold otherwise, restart on reset or a new game.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign step = enable && (count == LAST);
endmodule

// File: rtl/snake_engine.sv
// Snake body storage, motion, collision detection and pixel-query logic.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          rst,
  snake_engine_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];
  dir_t               dir, pend_dir;
  logic [LEN_W-1:0]   length;
  logic               hit_boundary, hit_self, eat;

  logic               step, step_ok, in_init;
  dir_t               req, cmp_dir;
  logic               req_valid, accept;
  logic [COORD_W-1:0] next_x, next_y;
  logic               at_edge, apple_hit, grow, self_hit;
  logic [LEN_W-1:0]   limit;

  assign in_init = (bus.game_state == INITIAL);

  move_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.game_state == RUNNING),
    .clear  (in_init),
    .step   (step)
  );

  // Once a collision is flagged the snake stays put until the next game.
  assign step_ok = step && !hit_boundary && !hit_self;

  // Button priority encode and reversal filter against the committed direction.
  always_comb begin
    req_valid = 1'b1;
    req       = RIGHT;
    if (bus.up)         req = UP;
    else if (bus.down)  req = DOWN;
    else if (bus.left)  req = LEFT;
    else if (bus.right) req = RIGHT;
    else                req_valid = 1'b0;
    cmp_dir = in_init ? RIGHT : dir;
    accept  = req_valid && (req != opposite_dir(cmp_dir));
  end

  // Candidate head cell for the pending direction and whether it leaves the grid.
  always_comb begin
    next_x  = seg_x[0];
    next_y  = seg_y[0];
    at_edge = 1'b0;
    case (pend_dir)
      UP: begin
        at_edge = (seg_y[0] == '0);
        next_y  = seg_y[0] - COORD_W'(1);
      end
      DOWN: begin
        at_edge = (seg_y[0] == Y_MAX);
        next_y  = seg_y[0] + COORD_W'(1);
      end
      LEFT: begin
        at_edge = (seg_x[0] == '0);
        next_x  = seg_x[0] - COORD_W'(1);
      end
      default: begin
        at_edge = (seg_x[0] == X_MAX);
        next_x  = seg_x[0] + COORD_W'(1);
      end
    endcase
  end

  // Apple/growth decision and self-collision; the tail cell is free only when not growing.
  always_comb begin
    apple_hit = (next_x == bus.apple_x) && (next_y == bus.apple_y);
    grow      = apple_hit && (length < LEN_W'(MAX_LEN));
    limit     = grow ? length : length - LEN_W'(1);
    self_hit  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < limit) && (seg_x[i] == next_x) && (seg_y[i] == next_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  // Body, direction and status registers: start position on reset/INITIAL, otherwise advance on steps.
  always_ff @(posedge clk) begin
    if (rst || in_init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= COORD_W'(GRID_W / 2 - i);
        seg_y[i] <= COORD_W'(GRID_H / 2);
      end
      dir          <= RIGHT;
      pend_dir     <= (!rst && accept) ? req : RIGHT;
      length       <= LEN_W'(INIT_LEN);
      hit_boundary <= 1'b0;
      hit_self     <= 1'b0;
      eat          <= 1'b0;
    end else begin
      eat <= 1'b0;
      if (bus.game_state != DIE && accept) begin
        pend_dir <= req;
      end
      if (step_ok) begin
        dir <= pend_dir;
        if (at_edge) begin
          hit_boundary <= 1'b1;
        end else if (self_hit) begin
          hit_self <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= next_x;
          seg_y[0] <= next_y;
          if (grow) length <= length + LEN_W'(1);
          eat <= apple_hit;
        end
      end
    end
  end

  // Renderer query against the active segments.
  always_comb begin
    bus.is_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < length) && (seg_x[i] == bus.query_x) && (seg_y[i] == bus.query_y)) begin
        bus.is_body = 1'b1;
      end
    end
    bus.is_head = (seg_x[0] == bus.query_x) && (seg_y[0] == bus.query_y);
  end

  assign bus.head_x       = seg_x[0];
  assign bus.head_y       = seg_y[0];
  assign bus.length       = length;
  assign bus.hit_boundary = hit_boundary;
  assign bus.hit_self     = hit_self;
  assign bus.eat          = eat;
endmodule

// File: tb/tb_snake_engine.sv
// Testbench for snake_engine on an 8x8 grid with a 4-cycle move tick.
module tb_snake_engine;
  localparam int GW = 8;
  localparam int GH = 8;
  localparam int CW = 4;
  localparam int ML = 5;
  localparam int IL = 3;
  localparam int TD = 4;
  localparam int LW = $clog2(ML + 1);

  localparam logic [1:0] GS_RUN  = 2'b00;
  localparam logic [1:0] GS_DIE  = 2'b01;
  localparam logic [1:0] GS_INIT = 2'b10;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  snake_engine_if #(.COORD_W(CW), .LEN_W(LW)) bus ();

  snake_engine #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW),
    .MAX_LEN(ML), .INIT_LEN(IL), .TICK_DIV(TD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: body as a queue of cells, head at the front.
  int mx[$];
  int my[$];
  int mdir, mpend, mcnt;
  bit mhb, mhs, meat;
  bit checking;

  function automatic int dx(input int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  // Advance the model on every rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    int  r, nx, ny, lim, oldpend;
    bit  stepnow, grow, ate, self;
    r = bus.up ? 0 : bus.down ? 1 : bus.left ? 2 : bus.right ? 3 : -1;
    meat = 1'b0;
    if (rst || bus.game_state == GS_INIT) begin
      mx = {};
      my = {};
      for (int i = 0; i < IL; i++) begin
        mx.push_back(GW / 2 - i);
        my.push_back(GH / 2);
      end
      mdir  = 3;
      mcnt  = 0;
      mhb   = 1'b0;
      mhs   = 1'b0;
      mpend = (!rst && r >= 0 && r != 2) ? r : 3;
      if (rst) checking = 1'b1;
    end else if (bus.game_state == GS_RUN) begin
      stepnow = (mcnt == TD - 1);
      mcnt    = stepnow ? 0 : mcnt + 1;
      oldpend = mpend;
      if (r >= 0 && r != opp(mdir)) mpend = r;
      if (stepnow && !mhb && !mhs) begin
        mdir = oldpend;
        nx = mx[0] + dx(oldpend);
        ny = my[0] + dy(oldpend);
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
          mhb = 1'b1;
        end else begin
          ate  = (nx == int'(bus.apple_x)) && (ny == int'(bus.apple_y));
          grow = ate && (mx.size() < ML);
          lim  = grow ? mx.size() : mx.size() - 1;
          self = 1'b0;
          for (int i = 0; i < lim; i++) begin
            if (mx[i] == nx && my[i] == ny) self = 1'b1;
          end
          if (self) begin
            mhs = 1'b1;
          end else begin
            mx.push_front(nx);
            my.push_front(ny);
            if (!grow) begin
              void'(mx.pop_back());
              void'(my.pop_back());
            end
            meat = ate;
          end
        end
      end
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    logic [2*CW+LW+4:0] got, want;
    bit eb, eh;
    if (checking) begin
      eb = 1'b0;
      for (int i = 0; i < mx.size(); i++) begin
        if (mx[i] == int'(bus.query_x) && my[i] == int'(bus.query_y)) eb = 1'b1;
      end
      eh   = (mx[0] == int'(bus.query_x)) && (my[0] == int'(bus.query_y));
      got  = {bus.head_x, bus.head_y, bus.length, bus.hit_boundary, bus.hit_self,
              bus.eat, bus.is_body, bus.is_head};
      want = {CW'(mx[0]), CW'(my[0]), LW'(mx.size()), mhb, mhs, meat, eb, eh};
      n_total++;
      if (got === want) n_pass++;
      else $display("[TB] FAIL cycle_model t=%0t got %h expected %h", $time, got, want);
    end
  end

  task automatic applyStimulus(input logic [1:0] gs, input logic [3:0] btn, input int n);
    bus.game_state = gs;
    {bus.up, bus.down, bus.left, bus.right} = btn;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic setApple(input int x, input int y);
    bus.apple_x = CW'(x);
    bus.apple_y = CW'(y);
  endtask

  task automatic checkQuery(input string name, input int x, input int y, input int exp_body);
    bus.query_x = CW'(x);
    bus.query_y = CW'(y);
    #1;
    checkOutput(name, int'(bus.is_body), exp_body);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    setApple(0, 7);
    bus.query_x = '0;
    bus.query_y = '0;
    applyStimulus(GS_INIT, B_NONE, 1);
    rst = 1'b0;
    checkOutput("reset_head_x", int'(bus.head_x), 4);
    checkOutput("reset_head_y", int'(bus.head_y), 4);
    checkOutput("reset_length", int'(bus.length), 3);
    checkOutput("reset_flags", int'({bus.hit_boundary, bus.hit_self, bus.eat}), 0);
    checkQuery("reset_body_tail", 2, 4, 1);
    checkQuery("reset_body_ahead", 5, 4, 0);

    applyStimulus(GS_RUN, B_NONE, 4);
    checkOutput("step1_head_x", int'(bus.head_x), 5);
    checkQuery("step1_tail_in", 3, 4, 1);
    checkQuery("step1_tail_out", 2, 4, 0);
    applyStimulus(GS_RUN, B_NONE, 4);
    checkOutput("step2_head_x", int'(bus.head_x), 6);
    applyStimulus(GS_RUN, B_NONE, 4);
    checkOutput("step3_head_x", int'(bus.head_x), 7);
    checkOutput("step3_no_boundary", int'(bus.hit_boundary), 0);
    applyStimulus(GS_RUN, B_NONE, 4);
    checkOutput("edge_boundary", int'(bus.hit_boundary), 1);
    checkOutput("edge_head_x", int'(bus.head_x), 7);
    applyStimulus(GS_INIT, B_NONE, 1);
    checkOutput("init_head_x", int'(bus.head_x), 4);
    checkOutput("init_clear_boundary", int'(bus.hit_boundary), 0);

    applyStimulus(GS_RUN, B_LEFT, 4);
    checkOutput("reverse_ignored_x", int'(bus.head_x), 5);
    checkOutput("reverse_ignored_y", int'(bus.head_y), 4);
    applyStimulus(GS_RUN, B_UP, 1);
    applyStimulus(GS_RUN, B_LEFT, 3);
    checkOutput("turn_up_x", int'(bus.head_x), 5);
    checkOutput("turn_up_y", int'(bus.head_y), 3);
    applyStimulus(GS_RUN, B_LEFT, 4);
    checkOutput("turn_left_x", int'(bus.head_x), 4);
    checkOutput("turn_left_y", int'(bus.head_y), 3);
    applyStimulus(GS_INIT, B_NONE, 1);

    setApple(5, 4);
    applyStimulus(GS_RUN, B_NONE, 4);
    checkOutput("eat1_pulse", int'(bus.eat), 1);
    checkOutput("eat1_length", int'(bus.length), 4);
    checkQuery("eat1_tail_kept", 2, 4, 1);
    applyStimulus(GS_RUN, B_NONE, 1);
    checkOutput("eat1_pulse_end", int'(bus.eat), 0);
    setApple(6, 4);
    applyStimulus(GS_RUN, B_NONE, 3);
    checkOutput("eat2_pulse", int'(bus.eat), 1);
    checkOutput("eat2_length", int'(bus.length), 5);
    setApple(7, 4);
    applyStimulus(GS_RUN, B_NONE, 4);
    checkOutput("eat_full_pulse", int'(bus.eat), 1);
    checkOutput("eat_full_length", int'(bus.length), 5);
    checkQuery("eat_full_tail_in", 3, 4, 1);
    checkQuery("eat_full_tail_out", 2, 4, 0);
    setApple(0, 7);

    applyStimulus(GS_RUN, B_UP, 4);
    checkOutput("coil_up_y", int'(bus.head_y), 3);
    applyStimulus(GS_RUN, B_LEFT, 4);
    checkOutput("coil_left_x", int'(bus.head_x), 6);
    applyStimulus(GS_RUN, B_DOWN, 4);
    checkOutput("self_hit", int'(bus.hit_self), 1);
    checkOutput("self_no_boundary", int'(bus.hit_boundary), 0);
    checkOutput("self_head_x", int'(bus.head_x), 6);
    checkOutput("self_head_y", int'(bus.head_y), 3);
    applyStimulus(GS_DIE, B_RIGHT, 20);
    checkOutput("die_head_x", int'(bus.head_x), 6);
    checkOutput("die_head_y", int'(bus.head_y), 3);
    checkOutput("die_self_sticky", int'(bus.hit_self), 1);
    applyStimulus(GS_INIT, B_NONE, 1);
    checkOutput("restart_head_x", int'(bus.head_x), 4);
    checkOutput("restart_length", int'(bus.length), 3);
    checkOutput("restart_self_clear", int'(bus.hit_self), 0);

    setApple(5, 4);
    applyStimulus(GS_RUN, B_NONE, 3);
    rst = 1'b1;
    applyStimulus(GS_RUN, B_NONE, 1);
    rst = 1'b0;
    checkOutput("rst_step_head_x", int'(bus.head_x), 4);
    checkOutput("rst_step_no_eat", int'(bus.eat), 0);
    checkOutput("rst_step_length", int'(bus.length), 3);
    applyStimulus(GS_RUN, B_NONE, 3);
    checkOutput("rst_counter_restart", int'(bus.head_x), 4);
    applyStimulus(GS_RUN, B_NONE, 1);
    checkOutput("rst_first_step_x", int'(bus.head_x), 5);
    checkOutput("rst_first_step_eat", int'(bus.eat), 1);
    checkOutput("rst_first_step_len", int'(bus.length), 4);

    @(posedge clk);
    #2;
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
Snake body/motion engine feeding the game-state FSM. Holds the snake's segment coordinates and moves it one grid cell per move tick. Produces the hit_boundary / hit_self inputs the FSM consumes, and consumes the FSM's game_state. Also serves a combinational pixel-query port for the VGA renderer and flags apple consumption.

Parameters:
GRID_W, 40, playfield width in cells (x = 0..GRID_W-1)
GRID_H, 30, playfield height in cells (y = 0..GRID_H-1)
COORD_W, 6, bits per coordinate; must satisfy 2^COORD_W >= max(GRID_W, GRID_H)
MAX_LEN, 16, segment storage depth
INIT_LEN, 3, length after reset/INITIAL; 2 <= INIT_LEN <= MAX_LEN
TICK_DIV, 25_000_000, clk cycles per move step (0.25 s at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
up, down, left, right  in  1 each  debounced direction buttons, level
game_state  in  2  from FSM: RUNNING=00, DIE=01, INITIAL=10
apple_x, apple_y  in  COORD_W each  current apple cell
query_x, query_y  in  COORD_W each  renderer cell query
hit_boundary  out  1  sticky: step would leave the grid
hit_self  out  1  sticky: step would enter own body
eat  out  1  one-cycle pulse: head moved onto apple
head_x, head_y  out  COORD_W each  segment 0 coordinates
length  out  $clog2(MAX_LEN+1)  active segment count
is_body  out  1  combinational: query cell matches any seg i < length
is_head  out  1  combinational: query cell equals segment 0

Behaviour:
- Reset state (rst=1, or any cycle with game_state==INITIAL): seg[i] = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN; entries i >= INIT_LEN are don't-care. dir=RIGHT, pend_dir=RIGHT, length=INIT_LEN, tick counter=0, hit_boundary=0, hit_self=0, eat=0.
- rst has priority over all other behaviour. INITIAL re-applies reset state every cycle, so a mid-game return to INITIAL restores the start body.
- Direction capture (any state except DIE): priority up > down > left > right. A request that is the exact opposite of the committed dir is ignored. Otherwise pend_dir <= request. Requests in INITIAL load pend_dir, so the first step uses it.
- Tick counter: counts only in RUNNING. Wraps at TICK_DIV-1, and that wrap cycle is the step cycle. It holds its value in DIE and is zeroed in INITIAL.
- Step cycle: dir <= pend_dir, then next = head + pend_dir.
  - Boundary: stepping left at x=0, right at x=GRID_W-1, up at y=0, or down at y=GRID_H-1 sets hit_boundary=1 the next cycle. Body is unchanged.
  - Growth: grow = (next == apple) && (length < MAX_LEN).
  - Self check compares next against seg[0..length-2], or seg[0..length-1] when grow (tail vacates only when not growing). A match sets hit_self=1 the next cycle and leaves the body unchanged.
  - If both boundary and self apply: boundary wins; only hit_boundary is set.
  - Otherwise: seg[i] <= seg[i-1] for i=1..MAX_LEN-1; seg[0] <= next.
  - If grow: length <= length+1.
  - If next == apple (including at MAX_LEN, where there is no growth): eat pulses 1 the cycle after the step.
- After a hit no further steps occur; the FSM leaves RUNNING next cycle. Hit flags stay set through DIE and clear in INITIAL.
- DIE: body, dir and counter are frozen. Buttons are ignored.
- Latency: hit/eat/head/length outputs update exactly 1 clk after the step cycle. is_body/is_head are purely combinational from registered segments.
- Up (y decrements) is toward row 0.

Decomposition:
- Package snake_pkg: game-state constants RUNNING/DIE/INITIAL (shared with the FSM), 2-bit dir encoding UP=0, DOWN=1, LEFT=2, RIGHT=3, and an opposite-dir function.
- Sub-module move_ticker (TICK_DIV, enable, clear -> step pulse) holds the divider. The segment shift register, collision compare and query logic stay in snake_engine.

Test Plan (TICK_DIV=4, GRID 8x8, MAX_LEN=5, INIT_LEN=3):
- rst 1 cycle, game_state=INITIAL -> head=(4,4), seg1=(3,4), seg2=(2,4), length=3, all flags 0. is_body=1 for query (2,4), 0 for (5,4).
- RUNNING, no buttons, 4 cycles -> head=(5,4), tail=(3,4). At 8 cycles -> head=(6,4). At 12 cycles -> hit_boundary=0 and head=(7,4). Next step -> hit_boundary=1 and head stays at (7,4).
- RUNNING dir=RIGHT, press left -> ignored, head x increments. Press up then left -> head y decrements on the next step, then x decrements on the following step.
- apple=(5,4), one step -> eat=1 for exactly 1 cycle, length=4, tail still (2,4). Repeat until length=5, then another apple -> eat=1 with length held at 5.
- length=5 body, sequence up, left, down steps -> hit_self=1 on the down step, body unchanged. game_state->DIE: no movement for 20 cycles. game_state->INITIAL: start body is restored and hit_self=0.
- rst asserted mid-step cycle while RUNNING -> next cycle shows the reset state, counter=0, and no eat/hit pulse.
